four_bit_incrementer_counter: RTL and testbench
===============================================

// Module: four_bit_incrementer_counter
// PURPOSE
//  Registered up-counter. The next-state adder is a gate-level incrementer
//  (a half-adder ripple chain, +1), the counterpart to the lab's +1111
//  decrementer. It holds a WIDTH-bit count, with optional load, enable,
//  a wrap pulse and a terminal-count flag. It is the LD-lab building block
//  for timers and sequencers.
// PARAMETERS
//  WIDTH     4  count width in bits (>=2)
//  SATURATE  0  0: wrap from max to 0;  1: stick at max, wrap never pulses
// PORTS
//  clk       in   1      rising-edge clock, the only clock
//  rst_n     in   1      synchronous, active-low reset
//  en        in   1      count enable; advances one step per enabled cycle
//  load      in   1      parallel load; has priority over en
//  load_val  in   WIDTH  value captured when load=1
//  count     out  WIDTH  registered count
//  wrap      out  1      registered pulse, 1 cycle, on max->0 transition
//  tc        out  1      combinational: count == all-ones
// BEHAVIOUR
//  - There is one clock. Reset is synchronous and active-low.
//    It is sampled only on the rising edge of clk.
//  - Priority per rising edge: rst_n=0 > load=1 > en=1 > hold.
//  - Reset: count=0, wrap=0, so tc=0. Reset overrides load/en in the same
//    cycle. Reset mid-count discards the count, with no partial step.
//  - Load: count <= load_val, wrap <= 0. load_val=max makes tc=1 next cycle.
//  - Enable, SATURATE=0: count <= count+1 mod 2^WIDTH.
//    wrap <= 1 iff old count == max; otherwise wrap <= 0.
//  - Enable, SATURATE=1: if count==max, count holds and wrap <= 0.
//    Otherwise count <= count+1.
//  - Hold (en=0, load=0): count unchanged, wrap <= 0.
//  - Latency: count reflects an accepted step/load 1 cycle after the edge.
//    wrap is aligned with the cycle in which count shows 0 after a wrap.
//  - tc = &count is purely combinational from the register.
//    It is not gated by en.
//  - Width rule: the incrementer is WIDTH bits wide, with a carry-out.
//    carry-out == old tc and drives wrap. No WIDTH+1 count bit is kept.
//  - load=1 and en=1 in the same cycle: the load wins, there is no
//    increment, and wrap=0.
//  - X on en/load while rst_n=0 must not propagate: reset dominates.
// STRUCTURE
//  - Sub-module: incrementer #(WIDTH)(a, s, cout).
//    It is a half_add ripple chain: a[0] with constant 1 in, each carry
//    feeds the next bit. It is built from the existing nand-based
//    half_add/andgate/xorgate cells, generated per bit.
//  - Top: incrementer instance, next-state mux (reset/load/inc/hold/sat),
//    WIDTH+1 flops (count, wrap), and the tc reduction.
//  - Shared constants include (lab_consts.vh): `CNT_ZERO, `CNT_MAX(WIDTH)
//    all-ones, reused by the decrementer benches.
//    No other typedefs are needed.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with en=1, load=1, load_val=9
//     -> count=0, wrap=0, tc=0 throughout.
//  2. Count: rst_n=1, en=1 for 17 cycles from 0 -> count 1..15,0,1.
//     tc=1 only at 15. wrap=1 only in the cycle count shows 0.
//  3. Load priority: load=1, en=1, load_val=14 -> count=14, wrap=0.
//     Then en=1 gives 15 (tc=1), then 0 (wrap=1).
//  4. Hold: count=6, en=0 for 5 cycles -> count stays 6, wrap=0.
//     Re-enable -> 7 next cycle.
//  5. Saturate (SATURATE=1): load 13, en=1 for 5 cycles
//     -> 14,15,15,15,15. wrap never 1. tc=1 from the 2nd step on.
//  6. Reset mid-run: count=11, en=1, rst_n=0 for 1 cycle -> count=0.
//     Release -> 1 on the next enabled edge. WIDTH=6 regression: wrap
//     at 63->0.

Source files
------------

// File: rtl/four_bit_incrementer_counter_pkg.sv
// Shared constants and next-state select encoding for the incrementer-based up-counter.
package four_bit_incrementer_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 4;
    localparam bit          DEFAULT_SATURATE = 1'b0;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_INC  = 2'd2,
        SEL_SAT  = 2'd3
    } nxt_sel_e;

endpackage

// File: rtl/four_bit_incrementer_counter_incrementer.sv
// Gate-level +1 incrementer: a ripple chain of NAND-built half adders seeded with carry-in 1.
module four_bit_incrementer_counter_incrementer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < int'(WIDTH); i++) begin : g_bit
            logic n_ac;
            logic n_a;
            logic n_c;
            // Four-NAND half adder: sum = a ^ c, carry = a & c
            assign n_ac     = ~(a[i] & c[i]);
            assign n_a      = ~(a[i] & n_ac);
            assign n_c      = ~(c[i] & n_ac);
            assign s[i]     = ~(n_a & n_c);
            assign c[i+1]   = ~n_ac;
        end
    endgenerate

    assign cout = c[WIDTH];

endmodule

// File: rtl/four_bit_incrementer_counter.sv
// Registered up-counter with load, enable, wrap pulse and terminal-count flag.
module four_bit_incrementer_counter
    import four_bit_incrementer_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter bit          SATURATE = DEFAULT_SATURATE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] inc_sum;
    logic             inc_cout;
    nxt_sel_e         sel;

    four_bit_incrementer_counter_incrementer #(
        .WIDTH (WIDTH)
    ) u_inc (
        .a    (count_q),
        .s    (inc_sum),
        .cout (inc_cout)
    );

    // Carry-out of the incrementer is high exactly when the old count is all-ones
    always_comb begin
        sel = SEL_HOLD;
        if (load) begin
            sel = SEL_LOAD;
        end else if (en) begin
            if (SATURATE && inc_cout) begin
                sel = SEL_SAT;
            end else begin
                sel = SEL_INC;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        case (sel)
            SEL_LOAD: count_d = load_val;
            SEL_INC: begin
                count_d = inc_sum;
                wrap_d  = inc_cout;
            end
            SEL_SAT:  count_d = count_q;
            default:  count_d = count_q;
        endcase
    end

    // Reset dominates, so unknown en/load during reset never reach the flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = &count_q;

endmodule

// File: tb/tb_four_bit_incrementer_counter.sv
// Directed bench: table-driven vectors for the default counter plus hand sequences for saturate and WIDTH=6.
module tb_four_bit_incrementer_counter;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       load;
        logic [3:0] lv;
        logic [3:0] exp_count;
        logic       exp_wrap;
        logic       exp_tc;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [5:0] load_val6;

    logic [3:0] count_w;
    logic       wrap_w;
    logic       tc_w;
    logic [3:0] count_s;
    logic       wrap_s;
    logic       tc_s;
    logic [5:0] count_6;
    logic       wrap_6;
    logic       tc_6;

    int checks;
    int errors;
    vec_t vecs[$];

    four_bit_incrementer_counter #(.WIDTH(4), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .count(count_w), .wrap(wrap_w), .tc(tc_w)
    );

    four_bit_incrementer_counter #(.WIDTH(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .count(count_s), .wrap(wrap_s), .tc(tc_s)
    );

    four_bit_incrementer_counter #(.WIDTH(6), .SATURATE(1'b0)) dut_w6 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val6),
        .count(count_6), .wrap(wrap_6), .tc(tc_6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic e, input logic l,
                         input logic [3:0] lv, input logic [5:0] lv6);
        @(negedge clk);
        rst_n     = r;
        en        = e;
        load      = l;
        load_val  = lv;
        load_val6 = lv6;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(logic r, logic e, logic l, logic [3:0] lv,
                                logic [3:0] c, logic w, logic t);
        vec_t v;
        v.rst_n = r; v.en = e; v.load = l; v.lv = lv;
        v.exp_count = c; v.exp_wrap = w; v.exp_tc = t;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0] sat_exp [5];
        logic       sat_tc  [5];
        checks = 0;
        errors = 0;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; load_val6 = '0;

        // Reset with load/en asserted
        add(0, 1, 1, 4'd9, 4'd0, 0, 0);
        add(0, 1, 1, 4'd9, 4'd0, 0, 0);
        // Free count through a wrap
        for (int k = 1; k <= 17; k++) begin
            logic [3:0] c;
            c = 4'(k % 16);
            add(1, 1, 0, 4'd0, c, (c == 4'd0), (c == 4'd15));
        end
        // Load beats enable, then step to max and wrap
        add(1, 1, 1, 4'd14, 4'd14, 0, 0);
        add(1, 1, 0, 4'd0,  4'd15, 0, 1);
        add(1, 1, 0, 4'd0,  4'd0,  1, 0);
        // Hold
        add(1, 0, 1, 4'd6, 4'd6, 0, 0);
        for (int k = 0; k < 5; k++) add(1, 0, 0, 4'd0, 4'd6, 0, 0);
        add(1, 1, 0, 4'd0, 4'd7, 0, 0);
        // tc not gated by en; wrap is a single-cycle pulse
        add(1, 0, 1, 4'd15, 4'd15, 0, 1);
        add(1, 0, 0, 4'd0,  4'd15, 0, 1);
        add(1, 1, 0, 4'd0,  4'd0,  1, 0);
        add(1, 0, 0, 4'd0,  4'd0,  0, 0);
        // Reset mid-run
        add(1, 0, 1, 4'd11, 4'd11, 0, 0);
        add(0, 1, 0, 4'd0,  4'd0,  0, 0);
        add(1, 1, 0, 4'd0,  4'd1,  0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst_n, vecs[i].en, vecs[i].load, vecs[i].lv, 6'd0);
            check($sformatf("vec%0d count", i), 32'(count_w), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d wrap",  i), 32'(wrap_w),  32'(vecs[i].exp_wrap));
            check($sformatf("vec%0d tc",    i), 32'(tc_w),    32'(vecs[i].exp_tc));
        end

        // Saturating counter: load 13 then five enabled steps
        sat_exp = '{4'd14, 4'd15, 4'd15, 4'd15, 4'd15};
        sat_tc  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        apply(1, 0, 1, 4'd13, 6'd0);
        check("sat load count", 32'(count_s), 32'd13);
        for (int k = 0; k < 5; k++) begin
            apply(1, 1, 0, 4'd0, 6'd0);
            check($sformatf("sat step%0d count", k), 32'(count_s), 32'(sat_exp[k]));
            check($sformatf("sat step%0d wrap",  k), 32'(wrap_s),  32'd0);
            check($sformatf("sat step%0d tc",    k), 32'(tc_s),    32'(sat_tc[k]));
        end

        // Unknown controls during reset must not leak through
        apply(0, 1'bx, 1'bx, 4'd5, 6'd5);
        check("xrst count", 32'(count_w), 32'd0);
        check("xrst wrap",  32'(wrap_w),  32'd0);
        check("xrst tc",    32'(tc_w),    32'd0);
        check("xrst sat count", 32'(count_s), 32'd0);

        // WIDTH=6 wrap at 63 -> 0
        apply(1, 0, 1, 4'd0, 6'd62);
        check("w6 load count", 32'(count_6), 32'd62);
        check("w6 load tc",    32'(tc_6),    32'd0);
        apply(1, 1, 0, 4'd0, 6'd0);
        check("w6 max count", 32'(count_6), 32'd63);
        check("w6 max tc",    32'(tc_6),    32'd1);
        check("w6 max wrap",  32'(wrap_6),  32'd0);
        apply(1, 1, 0, 4'd0, 6'd0);
        check("w6 wrap count", 32'(count_6), 32'd0);
        check("w6 wrap wrap",  32'(wrap_6),  32'd1);
        check("w6 wrap tc",    32'(tc_6),    32'd0);
        apply(1, 1, 0, 4'd0, 6'd0);
        check("w6 after count", 32'(count_6), 32'd1);
        check("w6 after wrap",  32'(wrap_6),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
